async_reset_fifo: RTL and testbench



---
 rtl/async_reset_fifo.sv | 110 +++++++++++
 tb/tb_async_reset_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/async_reset_fifo.sv
// async_reset_fifo: 16-entry x 4-bit synchronous FIFO with an asynchronous,
// active-high reset. It buffers words between a producer and a consumer.
// Each request is acknowledged for the cycle in which it is made. Read data
// is registered and appears one edge after the accepted read request.
module async_reset_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_wrReq_en,
  input  logic [DATA_W-1:0] io_wrReq_data,
  output logic              io_wrReq_valid,
  output logic              io_full,
  input  logic              io_rdReq_en,
  output logic [DATA_W-1:0] io_rdReq_data,
  output logic              io_rdReq_valid,
  output logic              io_empty
);

  localparam int ADDR_W = PTR_W - 1;

  // Storage is not reset. After a reset the pointers are equal, so no stale
  // word can be read.
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  // Each pointer has one extra MSB, the wrap bit. It tells full apart from
  // empty when the index bits are equal.
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;

  logic [DATA_W-1:0] r_rd_data_p1;
  logic              r_rd_vld_p1;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;

  // Status flags and request acceptance.
  // Both sides use the flags as they stand at the start of the cycle.
  // A read on a full FIFO therefore never makes room for a write in the
  // same cycle. A write on an empty FIFO never falls through to a read.
  always_comb begin
    w_wr_idx    = r_wr_ptr[ADDR_W-1:0];
    w_rd_idx    = r_rd_ptr[ADDR_W-1:0];
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_full      = (w_wr_idx == w_rd_idx) &&
                  (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);
    w_wr_accept = io_wrReq_en && !w_full;
    w_rd_accept = io_rdReq_en && !w_empty;
  end

  // Write pointer advances once per accepted push, wrapping modulo 2^PTR_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances once per accepted pop, wrapping modulo 2^PTR_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_rd_accept) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage write port. It holds data only and has no reset.
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_mem[w_wr_idx] <= io_wrReq_data;
    end
  end

  // ---- stage p1: registered read data and its one-cycle valid pulse ----
  // Read data holds its last popped value when no pop is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data_p1 <= '0;
    end else if (w_rd_accept) begin
      r_rd_data_p1 <= r_mem[w_rd_idx];
    end
  end

  // Valid pulses for exactly one cycle after each accepted pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_accept;
    end
  end

  // Drive the output ports.
  always_comb begin
    io_wrReq_valid = w_wr_accept;
    io_full        = w_full;
    io_empty       = w_empty;
    io_rdReq_data  = r_rd_data_p1;
    io_rdReq_valid = r_rd_vld_p1;
  end

endmodule

// File: tb/tb_async_reset_fifo.sv
// tb_async_reset_fifo: testbench for async_reset_fifo.
// The stimulus side keeps a reference queue of the words stored in the
// FIFO. For every read it expects to be accepted, it pushes the expected
// word onto a scoreboard queue. A separate monitor pops that queue each
// time the DUT presents io_rdReq_valid.
module tb_async_reset_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_wrReq_en = 1'b0;
  logic [3:0] io_wrReq_data = '0;
  logic       io_wrReq_valid;
  logic       io_full;
  logic       io_rdReq_en = 1'b0;
  logic [3:0] io_rdReq_data;
  logic       io_rdReq_valid;
  logic       io_empty;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] model_q[$];   // words currently held by the FIFO
  logic [3:0] exp_q[$];     // words expected on upcoming valid pulses

  async_reset_fifo #(.DATA_W(4), .FIFO_DEPTH(16), .PTR_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_wrReq_en    (io_wrReq_en),
    .io_wrReq_data  (io_wrReq_data),
    .io_wrReq_valid (io_wrReq_valid),
    .io_full        (io_full),
    .io_rdReq_en    (io_rdReq_en),
    .io_rdReq_data  (io_rdReq_data),
    .io_rdReq_valid (io_rdReq_valid),
    .io_empty       (io_empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented read word with the scoreboard head.
  always @(posedge clock) begin
    #1;
    if (io_rdReq_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("rd_data", {28'd0, io_rdReq_data}, {28'd0, e});
      end
    end
  end

  // Apply one cycle of requests. Flags are checked before the edge.
  task automatic do_cycle(input logic we, input logic [3:0] wd, input logic re);
    bit exp_empty, exp_full;
    @(negedge clock);
    io_wrReq_en   = we;
    io_wrReq_data = wd;
    io_rdReq_en   = re;
    #1;
    exp_empty = (model_q.size() == 0);
    exp_full  = (model_q.size() == 16);
    chk("empty", {31'd0, io_empty}, {31'd0, exp_empty});
    chk("full", {31'd0, io_full}, {31'd0, exp_full});
    chk("wr_valid", {31'd0, io_wrReq_valid}, {31'd0, (we && !exp_full)});
    if (re && !exp_empty) exp_q.push_back(model_q.pop_front());
    if (we && !exp_full) model_q.push_back(wd);
    @(posedge clock);
    #2;
    // The monitor consumes the pulse at +1, so nothing may remain pending.
    chk("rd_pulse_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic idle();
    do_cycle(1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_empty", {31'd0, io_empty}, 32'd1);
    chk("rst_full", {31'd0, io_full}, 32'd0);
    chk("rst_rd_valid", {31'd0, io_rdReq_valid}, 32'd0);
    chk("rst_rd_data", {28'd0, io_rdReq_data}, 32'd0);
    model_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Bound the run in case the DUT or the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset.
    #3;
    chk("por_empty", {31'd0, io_empty}, 32'd1);
    chk("por_full", {31'd0, io_full}, 32'd0);
    chk("por_rd_valid", {31'd0, io_rdReq_valid}, 32'd0);
    chk("por_rd_data", {28'd0, io_rdReq_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle();

    // Fill: data 0..15, then 7. The 17th write must be rejected.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 1'b0);
    chk("full_after_16", {31'd0, io_full}, 32'd1);
    do_cycle(1'b1, 4'd7, 1'b0);

    // Drain: expect 0..15 in order. The 17th read must produce no pulse.
    for (int i = 0; i < 16; i++) begin
      chk("drain_model_order", {28'd0, model_q[0]}, i);
      do_cycle(1'b0, 4'd0, 1'b1);
    end
    chk("empty_after_16", {31'd0, io_empty}, 32'd1);
    do_cycle(1'b0, 4'd0, 1'b1);
    idle();

    // Wrap: from a fresh reset push 10, pop 10, push 12, pop 12.
    do_reset();
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) do_cycle(1'b1, 4'(15 - i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("wrap_model_order", {28'd0, model_q[0]}, 15 - i);
      do_cycle(1'b0, 4'd0, 1'b1);
    end
    idle();

    // Simultaneous on full: the read pops the oldest word and the write is rejected.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'(i ^ 5), 1'b0);
    do_cycle(1'b1, 4'd9, 1'b1);
    chk("full_cleared", {31'd0, io_full}, 32'd0);
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 4'd0, 1'b1);

    // Simultaneous on empty: the write is accepted and no valid pulse appears.
    do_cycle(1'b1, 4'd12, 1'b1);
    chk("empty_cleared", {31'd0, io_empty}, 32'd0);
    do_cycle(1'b0, 4'd0, 1'b1);
    idle();

    // Reset mid-operation while a valid pulse is on the output.
    do_cycle(1'b1, 4'd1, 1'b0);
    do_cycle(1'b1, 4'd2, 1'b0);
    do_cycle(1'b1, 4'd3, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd_valid", {31'd0, io_rdReq_valid}, 32'd0);
    chk("mid_rst_rd_data", {28'd0, io_rdReq_data}, 32'd0);
    chk("mid_rst_empty", {31'd0, io_empty}, 32'd1);
    chk("mid_rst_full", {31'd0, io_full}, 32'd0);
    model_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    do_cycle(1'b1, 4'd9, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b1);
    do_cycle(1'b0, 4'd0, 1'b1);
    idle();

    // Random interleave against the reference queue.
    for (int i = 0; i < 1000; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    io_wrReq_en = 1'b0;
    io_rdReq_en = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
